// File: rtl/spmv_ctrl_pkg.sv
// Shared definitions for the sparse-matrix memory read sequencer:
// FSM state encoding and default sizing of the read path.
package spmv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_NUM_MODULES = 4;
    localparam int unsigned ISSUE_CNT_WIDTH     = 32;

endpackage

// File: rtl/spmv_issue_counter.sv
// Loadable up-counter with a terminal-count compare.
// at_terminal reflects the current count, so a caller that increments on the
// cycle at_terminal is high knows that increment is the last one.
module spmv_issue_counter #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal_value,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over increment; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (inc) begin
            count_d = count_q + ONE;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count       = count_q;
    assign at_terminal = (count_q == terminal_value);

endmodule

// File: rtl/spmv_mem_read_sequencer.sv
// Read sequencer for the memA / col_nos / multiples memories feeding the
// P_Emap_8 units. One address register is fanned out to all three memories;
// each advance is gated on the datapath request and on every P_Emap being
// ready. memories_preprocess is the registered advance, lining up with the
// synchronous memory read data one cycle later.
//
// Optional feature (macro SEQ_STALL_COUNTER_EN): adds output stall_cycles,
// a saturating count of FETCH cycles where the request was high but at least
// one P_Emap unit was not ready. Cleared on accepted start and on reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; addresses hold their last value
// FETCH | issuing row-groups, one per cycle when request and all ready
// DRAIN | last advance issued; its load strobe is on the output now
// DONE  | done pulse for one cycle, then back to IDLE
module spmv_mem_read_sequencer
    import spmv_ctrl_pkg::*;
#(
    parameter int unsigned                       memories_address_width      = DEFAULT_ADDR_WIDTH,
    parameter int unsigned                       no_of_row_by_vector_modules = DEFAULT_NUM_MODULES,
    parameter logic [memories_address_width-1:0] base_address                = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ISSUE_CNT_WIDTH-1:0]             total_with_additional_A,
    input  logic                                   memories_pre_preprocess,
    input  logic [no_of_row_by_vector_modules-1:0] you_can_read,
    output logic [memories_address_width-1:0]      memoryA_read_address,
    output logic [memories_address_width-1:0]      col_nos_read_address,
    output logic [memories_address_width-1:0]      multiples_read_address,
    output logic                                   memories_preprocess,
`ifdef SEQ_STALL_COUNTER_EN
    output logic [31:0]                            stall_cycles,
`endif
    output logic                                   busy,
    output logic                                   done
);

    localparam logic [memories_address_width-1:0] ADDR_ONE = memories_address_width'(1);
    localparam logic [ISSUE_CNT_WIDTH-1:0]        CNT_ONE  = ISSUE_CNT_WIDTH'(1);

    seq_state_e                         state_q, state_d;
    logic [memories_address_width-1:0]  addr_q, addr_d;
    logic [ISSUE_CNT_WIDTH-1:0]         total_q, total_d;
    logic                               preprocess_q, preprocess_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic                               all_ready;
    logic                               adv;
    logic                               start_ok;
    logic                               start_run;
    logic [ISSUE_CNT_WIDTH-1:0]         issue_count;
    logic                               issue_last;

    assign all_ready = &you_can_read;
    assign adv       = (state_q == ST_FETCH) && memories_pre_preprocess && all_ready;
    assign start_ok  = (state_q == ST_IDLE) && start;
    // A zero-length pass goes straight to DONE and must leave the
    // addresses and issue count untouched.
    assign start_run = start_ok && (total_with_additional_A != '0);

    // Issued row-group count; its terminal is the last group of the
    // latched total, so changes on the total input mid-pass are ignored.
    spmv_issue_counter #(
        .WIDTH       (ISSUE_CNT_WIDTH),
        .RESET_VALUE ('0)
    ) u_issue_counter (
        .clk            (clk),
        .reset          (reset),
        .load           (start_run),
        .load_value     ('0),
        .inc            (adv),
        .terminal_value (total_q - CNT_ONE),
        .count          (issue_count),
        .at_terminal    (issue_last)
    );

    // Next-state, address and registered-output computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        total_d = total_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (start_run) begin
                        total_d = total_with_additional_A;
                        addr_d  = base_address;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (adv) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        preprocess_d = adv;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // FSM and output registers; reset also drops any pending load strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= base_address;
            total_q      <= '0;
            preprocess_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
            preprocess_q <= preprocess_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef SEQ_STALL_COUNTER_EN
    logic [31:0] stall_q, stall_d;

    // Count request-high / not-all-ready cycles in FETCH, saturating.
    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if ((state_q == ST_FETCH) && memories_pre_preprocess && !all_ready
                     && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign memoryA_read_address   = addr_q;
    assign col_nos_read_address   = addr_q;
    assign multiples_read_address = addr_q;
    assign memories_preprocess    = preprocess_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule

// File: tb/tb_spmv_mem_read_sequencer.sv
// Scoreboard bench for spmv_mem_read_sequencer. Stimulus pushes the expected
// issued addresses and the expected completion of each accepted pass; a
// negedge monitor pops and compares on every load strobe and done pulse.
// A second instance with a 4-bit address checks wrap-around.
module tb_spmv_mem_read_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [31:0] total;
    logic        req;
    logic [3:0]  ycr;
    logic [31:0] a_addr, c_addr, m_addr;
    logic        mp, busy, done;

    logic        w_start;
    logic [31:0] w_total;
    logic        w_req;
    logic [3:0]  w_ycr;
    logic [3:0]  w_a, w_c, w_m;
    logic        w_mp, w_busy, w_done;

`ifdef SEQ_STALL_COUNTER_EN
    logic [31:0] stall_cycles;
    logic [31:0] w_stall_cycles;
`endif

    spmv_mem_read_sequencer #(
        .memories_address_width      (32),
        .no_of_row_by_vector_modules (4),
        .base_address                (32'd0)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .total_with_additional_A (total),
        .memories_pre_preprocess (req),
        .you_can_read            (ycr),
        .memoryA_read_address    (a_addr),
        .col_nos_read_address    (c_addr),
        .multiples_read_address  (m_addr),
        .memories_preprocess     (mp),
`ifdef SEQ_STALL_COUNTER_EN
        .stall_cycles            (stall_cycles),
`endif
        .busy                    (busy),
        .done                    (done)
    );

    spmv_mem_read_sequencer #(
        .memories_address_width      (4),
        .no_of_row_by_vector_modules (4),
        .base_address                (4'd14)
    ) dut_wrap (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (w_start),
        .total_with_additional_A (w_total),
        .memories_pre_preprocess (w_req),
        .you_can_read            (w_ycr),
        .memoryA_read_address    (w_a),
        .col_nos_read_address    (w_c),
        .multiples_read_address  (w_m),
        .memories_preprocess     (w_mp),
`ifdef SEQ_STALL_COUNTER_EN
        .stall_cycles            (w_stall_cycles),
`endif
        .busy                    (w_busy),
        .done                    (w_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int total;
        int start_cyc;
    } done_exp_t;

    logic [31:0] addr_exp_q[$];
    done_exp_t   done_exp_q[$];

    logic [31:0] prev_addr;
    int          n_strobes   = 0;
    int          last_mp_cyc = -10;
    done_exp_t   de;

    // Monitor: every strobe must carry the next expected issued address
    // (the address presented the cycle before), every done must match an
    // expected pass end with the right strobe count and latency.
    always @(negedge clk) begin
        if (mp === 1'b1) begin
            chk("fanout_col_nos", c_addr, a_addr);
            chk("fanout_multiples", m_addr, a_addr);
            if (addr_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe for addr %0h, expected none (cycle %0d)", prev_addr, cyc);
            end else begin
                chk("strobe_addr", prev_addr, addr_exp_q.pop_front());
            end
            n_strobes++;
            last_mp_cyc = cyc;
        end
        if (done === 1'b1) begin
            if (done_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                de = done_exp_q.pop_front();
                chk("strobe_count", n_strobes, de.total);
                if (de.total == 0) chk("done_latency_zero", cyc, de.start_cyc + 1);
                else               chk("done_after_last_strobe", cyc, last_mp_cyc + 1);
                chk("busy_during_done", busy, 1'b1);
            end
            n_strobes = 0;
        end
        if (reset === 1'b1) n_strobes = 0;
        prev_addr = a_addr;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pass(input int t);
        start = 1'b1;
        total = t;
        for (int i = 0; i < t; i++) addr_exp_q.push_back(32'(i));
        done_exp_q.push_back('{t, cyc});
        step();
        start = 1'b0;
        total = 32'd0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        chk({name, "_returns_idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    logic [3:0] wexp [5];

    initial begin
        int  n;
        bit  seen;
        reset   = 1'b1;
        start   = 1'b0;
        total   = '0;
        req     = 1'b0;
        ycr     = 4'hF;
        w_start = 1'b0;
        w_total = '0;
        w_req   = 1'b0;
        w_ycr   = 4'hF;
        step();
        step();
        step();
        chk("reset_addr", a_addr, 32'd0);
        chk("reset_mp", mp, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_wrap_addr", w_a, 4'd14);
`ifdef SEQ_STALL_COUNTER_EN
        chk("reset_stall", stall_cycles, 32'd0);
`endif
        reset = 1'b0;
        step();

        // Basic pass, with request high already in IDLE.
        req = 1'b1;
        step();
        chk("idle_req_ignored", a_addr, 32'd0);
        start_pass(5);
        chk("basic_busy", busy, 1'b1);
        chk("basic_first_addr", a_addr, 32'd0);
        wait_idle("basic", 20);
        chk("basic_end_addr", a_addr, 32'd5);

        // Stall on one P_Emap not ready after the second advance,
        // then a request-low gap that must not count as a stall.
        start_pass(4);
        step();
        step();
        ycr = 4'hE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr_frozen", a_addr, 32'd2);
            chk("stall_no_strobe", mp, 1'b0);
        end
        ycr = 4'hF;
        step();
        req = 1'b0;
        step();
        step();
        chk("req_low_addr_hold", a_addr, 32'd3);
        req = 1'b1;
        wait_idle("stall", 20);
        chk("stall_end_addr", a_addr, 32'd4);
`ifdef SEQ_STALL_COUNTER_EN
        chk("stall_cycles", stall_cycles, 32'd3);
`endif

        // Zero total: done one cycle after start, address untouched.
        start_pass(0);
        chk("zero_mp", mp, 1'b0);
        chk("zero_addr_hold", a_addr, 32'd4);
        step();
        chk("zero_idle", busy, 1'b0);
        chk("zero_addr_after", a_addr, 32'd4);

        // Start while busy is ignored.
        start_pass(3);
        step();
        start = 1'b1;
        total = 32'd9;
        step();
        start = 1'b0;
        total = 32'd0;
        wait_idle("restart_ignored", 20);
        chk("restart_end_addr", a_addr, 32'd3);

        // Reset after two advances of a six-group pass.
        start_pass(6);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_addr", a_addr, 32'd0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_mp", mp, 1'b0);
        chk("midreset_done", done, 1'b0);
        addr_exp_q.delete();
        done_exp_q.delete();
        for (int i = 0; i < 4; i++) step();
        start_pass(3);
        wait_idle("after_reset", 20);
        chk("after_reset_addr", a_addr, 32'd3);

        // Address wrap on the 4-bit instance.
        wexp = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        w_req   = 1'b1;
        w_start = 1'b1;
        w_total = 32'd4;
        step();
        w_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wrap_addr", w_a, wexp[i]);
            step();
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 6) begin
            if (w_done === 1'b1) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk("wrap_done", seen, 1'b1);
        chk("wrap_final_addr", w_a, 4'd2);

        step();
        step();
        chk("addr_queue_drained", addr_exp_q.size(), 0);
        chk("done_queue_drained", done_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
